// File: rtl/ama_riscv_imem_loader_pkg.sv
// Shared types for the IMEM boot loader: FSM state encoding,
// header length and the per-state output flag decode.
package ama_riscv_imem_loader_pkg;

   typedef enum logic [2:0] {
      LDR_IDLE  = 3'd0,
      LDR_HDR   = 3'd1,
      LDR_DATA  = 3'd2,
      LDR_FLUSH = 3'd3,
      LDR_DONE  = 3'd4,
      LDR_ERR   = 3'd5
   } ldr_state_t;

   localparam int LDR_HDR_BYTES = 4;

   typedef struct packed {
      logic s_ready;
      logic busy;
      logic done;
      logic err;
      logic core_rst;
   } ldr_flags_t;

   // Status outputs as a pure function of the state being entered,
   // so they can be registered together with the state itself.
   function automatic ldr_flags_t ldr_flags(input ldr_state_t st);
      ldr_flags_t f;
      f = '{s_ready: 1'b0, busy: 1'b0, done: 1'b0,
            err: 1'b0, core_rst: 1'b1};
      unique case (st)
         LDR_HDR: begin
            f.s_ready = 1'b1;
            f.busy    = 1'b1;
         end
         LDR_DATA: begin
            f.s_ready = 1'b1;
            f.busy    = 1'b1;
         end
         LDR_FLUSH: f.busy = 1'b1;
         LDR_DONE: begin
            f.done     = 1'b1;
            f.core_rst = 1'b0;
         end
         LDR_ERR: f.err = 1'b1;
         default: ;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/ama_riscv_byte_packer.sv
// Assembles 4 little-endian stream bytes into a 32-bit word.
// Ports: clk, rst_n (sync, active-low), clear, byte_en, byte_in -> word, word_valid.
module ama_riscv_byte_packer
   import ama_riscv_imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_IDX = 2'(LDR_HDR_BYTES - 1);

   logic [1:0]  idx;
   logic [23:0] low;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         idx <= 2'd0;
         low <= 24'd0;
      end else if (byte_en) begin
         idx <= idx + 2'd1;
         unique case (idx)
            2'd0: low[7:0]   <= byte_in;
            2'd1: low[15:8]  <= byte_in;
            2'd2: low[23:16] <= byte_in;
            default: ;
         endcase
      end
   end

   // The top byte is taken straight from the stream so the full word
   // is available in the same cycle as the 4th handshake.
   assign word       = {byte_in, low};
   assign word_valid = byte_en && (idx == LAST_IDX);

endmodule

// File: rtl/ama_riscv_imem_loader.sv
// Boot loader: streams a counted image into IMEM port A, holds core in reset.
// Ports: clk, rst_n, start, s_data/s_valid/s_ready, imem_*, core_rst, busy, done, err.
module ama_riscv_imem_loader
   import ama_riscv_imem_loader_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              imem_ena,
   output logic [3:0]        imem_wea,
   output logic [ADDR_W-1:0] imem_addra,
   output logic [31:0]       imem_dina,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

   ldr_state_t        state;
   ldr_flags_t        flg;
   logic [ADDR_W-1:0] word_idx;
   logic [ADDR_W-1:0] last_idx;

   logic        hs;
   logic        start_go;
   logic [31:0] word;
   logic        word_valid;
   logic        cnt_zero;
   logic        cnt_ok;

   assign hs = s_valid && s_ready;

   assign start_go = start &&
      ((state == LDR_IDLE) || (state == LDR_DONE) || (state == LDR_ERR));

   ama_riscv_byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start_go),
      .byte_en    (hs),
      .byte_in    (s_data),
      .word       (word),
      .word_valid (word_valid)
   );

   // Upper bits must be zero before the narrow compare is meaningful.
   assign cnt_zero = (word == 32'd0);
   assign cnt_ok   = (word[31:ADDR_W+1] == '0) &&
                     (word[ADDR_W:0] <= MAX_CNT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= LDR_IDLE;
         flg        <= ldr_flags(LDR_IDLE);
         word_idx   <= '0;
         last_idx   <= '0;
         imem_ena   <= 1'b0;
         imem_wea   <= 4'h0;
         imem_addra <= '0;
         imem_dina  <= 32'd0;
      end else begin
         imem_ena <= 1'b0;
         imem_wea <= 4'h0;
         unique case (state)
            LDR_IDLE, LDR_DONE, LDR_ERR: begin
               if (start) begin
                  state <= LDR_HDR;
                  flg   <= ldr_flags(LDR_HDR);
               end
            end
            LDR_HDR: begin
               if (word_valid) begin
                  if (!cnt_ok) begin
                     state <= LDR_ERR;
                     flg   <= ldr_flags(LDR_ERR);
                  end else if (cnt_zero) begin
                     state <= LDR_FLUSH;
                     flg   <= ldr_flags(LDR_FLUSH);
                  end else begin
                     state    <= LDR_DATA;
                     flg      <= ldr_flags(LDR_DATA);
                     word_idx <= '0;
                     // count == 2**ADDR_W truncates to 0; minus 1 gives all-ones.
                     last_idx <= word[ADDR_W-1:0] - 1'b1;
                  end
               end
            end
            LDR_DATA: begin
               if (word_valid) begin
                  imem_ena   <= 1'b1;
                  imem_wea   <= 4'hF;
                  imem_addra <= word_idx;
                  imem_dina  <= word;
                  if (word_idx == last_idx) begin
                     state <= LDR_FLUSH;
                     flg   <= ldr_flags(LDR_FLUSH);
                  end else begin
                     word_idx <= word_idx + 1'b1;
                  end
               end
            end
            LDR_FLUSH: begin
               state <= LDR_DONE;
               flg   <= ldr_flags(LDR_DONE);
            end
            default: begin
               state <= LDR_IDLE;
               flg   <= ldr_flags(LDR_IDLE);
            end
         endcase
      end
   end

   assign s_ready  = flg.s_ready;
   assign busy     = flg.busy;
   assign done     = flg.done;
   assign err      = flg.err;
   assign core_rst = flg.core_rst;

endmodule
